// File: rtl/dcache_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : dcache_queue_if
// Brief    : Request side (SLB) and memory-controller side (MC) signal bundle
//            for dcache_queue.
// Revision : 1.0 - initial release
// ============================================================================
interface dcache_queue_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 3,
    parameter int NICK_W = 4
);
    logic              iSLB_en;
    logic              iSLB_ls;
    logic [ADDR_W-1:0] iSLB_pc;
    logic [DATA_W-1:0] iSLB_dt;
    logic [LEN_W-1:0]  iSLB_len;
    logic [NICK_W-1:0] iSLB_nick;
    logic              oSLB_en;
    logic              oSLB_done;
    logic [DATA_W-1:0] oSLB_dt;
    logic [NICK_W-1:0] oSLB_nick;
    logic [1:0]        iMC_wait;
    logic              iMC_done;
    logic [DATA_W-1:0] iMC_dt;
    logic              oMC_en;
    logic              oMC_ls;
    logic [ADDR_W-1:0] oMC_pc;
    logic [DATA_W-1:0] oMC_dt;
    logic [LEN_W-1:0]  oMC_len;

    modport slave (
        input  iSLB_en, iSLB_ls, iSLB_pc, iSLB_dt, iSLB_len, iSLB_nick,
        input  iMC_wait, iMC_done, iMC_dt,
        output oSLB_en, oSLB_done, oSLB_dt, oSLB_nick,
        output oMC_en, oMC_ls, oMC_pc, oMC_dt, oMC_len
    );

    modport master (
        output iSLB_en, iSLB_ls, iSLB_pc, iSLB_dt, iSLB_len, iSLB_nick,
        output iMC_wait, iMC_done, iMC_dt,
        input  oSLB_en, oSLB_done, oSLB_dt, oSLB_nick,
        input  oMC_en, oMC_ls, oMC_pc, oMC_dt, oMC_len
    );
endinterface
`default_nettype wire

// File: rtl/dcache_queue.sv
`default_nettype none
// ============================================================================
// Module   : dcache_queue
// Brief    : In-order load/store request FIFO between the SLB and memctrl.
//            Define DCACHE_QUEUE_FWD_EN to add store-to-load forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 3,
    parameter int NICK_W = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic rdy,
    dcache_queue_if.slave bus
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

    logic              r_ls   [DEPTH];
    logic [ADDR_W-1:0] r_pc   [DEPTH];
    logic [DATA_W-1:0] r_dt   [DEPTH];
    logic [LEN_W-1:0]  r_len  [DEPTH];
    logic [NICK_W-1:0] r_nick [DEPTH];

    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;
    logic               r_done;
    logic [DATA_W-1:0]  r_done_dt;
    logic [NICK_W-1:0]  r_done_nick;

    logic              w_empty;
    logic              w_full;
    logic              w_slb_en;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_fwd;
    logic [DATA_W-1:0] w_fwd_dt;
    logic              w_unused_wait;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == c_FULL);
    assign w_slb_en = rdy & ~rst & ~w_full;
    assign w_accept = bus.iSLB_en & w_slb_en;
    assign w_pop    = rdy & bus.iMC_done & ~w_empty;
    assign w_push   = w_accept & ~w_fwd;

    // Only the data-port busy flag gates issue.
    assign w_unused_wait = bus.iMC_wait[0];

    assign bus.oSLB_en   = w_slb_en;
    assign bus.oSLB_done = r_done;
    assign bus.oSLB_dt   = r_done_dt;
    assign bus.oSLB_nick = r_done_nick;

    assign bus.oMC_en  = rdy & ~rst & ~w_empty & ~bus.iMC_wait[1];
    assign bus.oMC_ls  = w_empty ? 1'b0 : r_ls[r_head];
    assign bus.oMC_pc  = w_empty ? '0   : r_pc[r_head];
    assign bus.oMC_dt  = w_empty ? '0   : r_dt[r_head];
    assign bus.oMC_len = w_empty ? '0   : r_len[r_head];

`ifdef DCACHE_QUEUE_FWD_EN
    localparam int c_BYTES = DATA_W / 8;

    logic              w_fwd_hit;
    logic [DATA_W-1:0] w_fwd_src;

    // Scan oldest to youngest so the last hit is the youngest matching store.
    always_comb begin
        w_fwd_hit = 1'b0;
        w_fwd_src = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (c_CNT_W'(i) < r_count) begin
                if (r_ls[r_head + c_PTR_W'(i)] &&
                    (r_pc[r_head + c_PTR_W'(i)] == bus.iSLB_pc) &&
                    (r_len[r_head + c_PTR_W'(i)] == bus.iSLB_len)) begin
                    w_fwd_hit = 1'b1;
                    w_fwd_src = r_dt[r_head + c_PTR_W'(i)];
                end
            end
        end
    end

    always_comb begin
        w_fwd_dt = '0;
        for (int b = 0; b < c_BYTES; b++) begin
            if (b < int'(bus.iSLB_len)) begin
                w_fwd_dt[8*b +: 8] = w_fwd_src[8*b +: 8];
            end
        end
    end

    // A completion from memctrl in the same cycle takes priority over forwarding.
    assign w_fwd = w_accept & ~bus.iSLB_ls & ~bus.iMC_done & w_fwd_hit;
`else
    assign w_fwd    = 1'b0;
    assign w_fwd_dt = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_done      <= 1'b0;
            r_done_dt   <= '0;
            r_done_nick <= '0;
        end else if (rdy) begin
            if (w_push) begin
                r_tail <= r_tail + c_PTR_ONE;
            end
            if (w_pop) begin
                r_head <= r_head + c_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CNT_ONE;
            end
            r_done <= w_pop | w_fwd;
            if (w_pop) begin
                r_done_nick <= r_nick[r_head];
                r_done_dt   <= r_ls[r_head] ? '0 : bus.iMC_dt;
            end else if (w_fwd) begin
                r_done_nick <= bus.iSLB_nick;
                r_done_dt   <= w_fwd_dt;
            end
        end
    end

    // Entry payload needs no reset; validity is tracked by head/count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ls[r_tail]   <= bus.iSLB_ls;
            r_pc[r_tail]   <= bus.iSLB_pc;
            r_dt[r_tail]   <= bus.iSLB_dt;
            r_len[r_tail]  <= bus.iSLB_len;
            r_nick[r_tail] <= bus.iSLB_nick;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_dcache_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_queue
// Brief    : Directed scenarios plus randomized traffic against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_queue;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 3;
    localparam int NICK_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    dcache_queue_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .NICK_W(NICK_W)) bus ();

    dcache_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .NICK_W(NICK_W)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              ls;
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] dt;
        logic [LEN_W-1:0]  len;
        logic [NICK_W-1:0] nick;
    } req_t;

    // Reference model: a plain queue of requests and the last completion.
    req_t              m_q[$];
    logic              m_done = 1'b0;
    logic [DATA_W-1:0] m_dt   = '0;
    logic [NICK_W-1:0] m_nick = '0;

    function automatic logic [DATA_W-1:0] mask_len(input logic [DATA_W-1:0] d, input logic [LEN_W-1:0] len);
        logic [63:0] m;
        m = (64'd1 << (8 * int'(len))) - 64'd1;
        return d & m[DATA_W-1:0];
    endfunction

    task automatic model_update();
        bit   acc;
        bit   fwd;
        logic nd;
        req_t e;
        if (rst) begin
            m_q.delete(); m_done = 1'b0; m_dt = '0; m_nick = '0;
            return;
        end
        if (!rdy) return;
        acc = bus.iSLB_en && (m_q.size() < DEPTH);
        fwd = 1'b0;
        nd  = 1'b0;
`ifdef DCACHE_QUEUE_FWD_EN
        if (acc && !bus.iSLB_ls && !bus.iMC_done) begin
            for (int j = m_q.size() - 1; j >= 0; j--) begin
                if (m_q[j].ls && m_q[j].pc == bus.iSLB_pc && m_q[j].len == bus.iSLB_len) begin
                    fwd = 1'b1; nd = 1'b1; m_nick = bus.iSLB_nick; m_dt = mask_len(m_q[j].dt, bus.iSLB_len);
                    break;
                end
            end
        end
`endif
        if (bus.iMC_done && m_q.size() > 0) begin
            e = m_q.pop_front();
            nd = 1'b1; m_nick = e.nick; m_dt = e.ls ? '0 : bus.iMC_dt;
        end
        if (acc && !fwd) begin
            e.ls = bus.iSLB_ls; e.pc = bus.iSLB_pc; e.dt = bus.iSLB_dt; e.len = bus.iSLB_len; e.nick = bus.iSLB_nick;
            m_q.push_back(e);
        end
        m_done = nd;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_req(input logic en, input logic ls, input logic [ADDR_W-1:0] pc, input logic [DATA_W-1:0] dt,
                           input logic [LEN_W-1:0] len, input logic [NICK_W-1:0] nick);
        bus.iSLB_en = en; bus.iSLB_ls = ls; bus.iSLB_pc = pc; bus.iSLB_dt = dt; bus.iSLB_len = len; bus.iSLB_nick = nick;
    endtask

    task automatic set_mc(input logic [1:0] w, input logic done, input logic [DATA_W-1:0] dt);
        bus.iMC_wait = w; bus.iMC_done = done; bus.iMC_dt = dt;
    endtask

    task automatic idle_req();
        set_req(1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 4'd0);
    endtask

    task automatic test_reset();
        rdy = 1'b1; rst = 1'b1;
        tick(); tick();
        n_checks++; if (bus.oSLB_en !== 1'b0) begin n_fail++; $display("FAIL reset_slb_en got=%0b exp=0", bus.oSLB_en); end
        n_checks++; if (bus.oMC_en !== 1'b0) begin n_fail++; $display("FAIL reset_mc_en got=%0b exp=0", bus.oMC_en); end
        n_checks++; if ({bus.oSLB_done, bus.oSLB_dt, bus.oSLB_nick} !== '0)
            begin n_fail++; $display("FAIL reset_done got=%0b/%0h/%0h exp=0/0/0", bus.oSLB_done, bus.oSLB_dt, bus.oSLB_nick); end
        rst = 1'b0; #1;
        n_checks++; if (bus.oSLB_en !== 1'b1) begin n_fail++; $display("FAIL post_reset_slb_en got=%0b exp=1", bus.oSLB_en); end
        n_checks++; if (bus.oMC_en !== 1'b0) begin n_fail++; $display("FAIL post_reset_mc_en got=%0b exp=0", bus.oMC_en); end
    endtask

    task automatic test_single_load();
        set_mc(2'b00, 1'b0, 32'h0);
        set_req(1'b1, 1'b0, 32'h100, 32'h0, 3'd4, 4'd3);
        tick(); idle_req(); #1;
        n_checks++; if (bus.oMC_en !== 1'b1 || bus.oMC_pc !== 32'h100 || bus.oMC_len !== 3'd4 || bus.oMC_ls !== 1'b0)
            begin n_fail++; $display("FAIL single_issue got=%0b/%0h/%0d exp=1/100/4", bus.oMC_en, bus.oMC_pc, bus.oMC_len); end
        set_mc(2'b00, 1'b1, 32'hDEADBEEF);
        tick(); set_mc(2'b00, 1'b0, 32'h0); #1;
        n_checks++; if (bus.oSLB_done !== 1'b1 || bus.oSLB_nick !== 4'd3 || bus.oSLB_dt !== 32'hDEADBEEF)
            begin n_fail++; $display("FAIL single_done got=%0b/%0h/%0h exp=1/3/deadbeef", bus.oSLB_done, bus.oSLB_nick, bus.oSLB_dt); end
        n_checks++; if (bus.oMC_en !== 1'b0) begin n_fail++; $display("FAIL single_empty got=%0b exp=0", bus.oMC_en); end
        tick();
        n_checks++; if (bus.oSLB_done !== 1'b0) begin n_fail++; $display("FAIL single_pulse got=%0b exp=0", bus.oSLB_done); end
    endtask

    task automatic test_fill_drain();
        set_mc(2'b10, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            set_req(1'b1, 1'b0, 32'h40 + 32'(16 * i), 32'h0, 3'd4, 4'(i));
            tick();
        end
        idle_req(); #1;
        n_checks++; if (bus.oSLB_en !== 1'b0 || bus.oMC_en !== 1'b0)
            begin n_fail++; $display("FAIL fill_full got=%0b/%0b exp=0/0", bus.oSLB_en, bus.oMC_en); end
        for (int i = 0; i < 4; i++) begin
            set_mc(2'b00, 1'b1, 32'hC0DE0000 + 32'(i)); #1;
            n_checks++; if (bus.oMC_en !== 1'b1 || bus.oMC_pc !== 32'h40 + 32'(16 * i))
                begin n_fail++; $display("FAIL drain_head%0d got=%0b/%0h exp=1/%0h", i, bus.oMC_en, bus.oMC_pc, 32'h40 + 32'(16 * i)); end
            tick();
            n_checks++; if (bus.oSLB_done !== 1'b1 || bus.oSLB_nick !== 4'(i) || bus.oSLB_dt !== 32'hC0DE0000 + 32'(i))
                begin n_fail++; $display("FAIL drain_done%0d got=%0b/%0h/%0h exp=1/%0h", i, bus.oSLB_done, bus.oSLB_nick, bus.oSLB_dt, i); end
        end
        set_mc(2'b00, 1'b0, 32'h0); #1;
        n_checks++; if (bus.oMC_en !== 1'b0) begin n_fail++; $display("FAIL drain_empty got=%0b exp=0", bus.oMC_en); end
    endtask

    task automatic test_full_push_pop();
        set_mc(2'b10, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            set_req(1'b1, 1'b0, 32'h500 + 32'(4 * i), 32'h0, 3'd4, 4'(i));
            tick();
        end
        set_req(1'b1, 1'b0, 32'h5F0, 32'h0, 3'd4, 4'd15);
        set_mc(2'b00, 1'b1, 32'h1000); #1;
        n_checks++; if (bus.oSLB_en !== 1'b0) begin n_fail++; $display("FAIL full_slb_en got=%0b exp=0", bus.oSLB_en); end
        tick();
        n_checks++; if (bus.oSLB_done !== 1'b1 || bus.oSLB_nick !== 4'd0)
            begin n_fail++; $display("FAIL full_pop got=%0b/%0h exp=1/0", bus.oSLB_done, bus.oSLB_nick); end
        idle_req(); set_mc(2'b00, 1'b0, 32'h0); #1;
        n_checks++; if (bus.oSLB_en !== 1'b1) begin n_fail++; $display("FAIL after_pop_slb_en got=%0b exp=1", bus.oSLB_en); end
        for (int k = 0; k < 6; k++) begin
            set_req(1'b1, 1'b0, 32'h600 + 32'(4 * k), 32'h0, 3'd4, 4'(4 + k));
            set_mc(2'b00, 1'b1, 32'h2000 + 32'(k)); #1;
            n_checks++; if (bus.oSLB_en !== 1'b1) begin n_fail++; $display("FAIL pp_slb_en%0d got=%0b exp=1", k, bus.oSLB_en); end
            tick();
            n_checks++; if (bus.oSLB_done !== 1'b1 || bus.oSLB_nick !== 4'(k + 1) || bus.oSLB_dt !== 32'h2000 + 32'(k))
                begin n_fail++; $display("FAIL pp_done%0d got=%0b/%0h/%0h exp=1/%0h/%0h", k, bus.oSLB_done, bus.oSLB_nick, bus.oSLB_dt, k + 1, 32'h2000 + k); end
        end
        idle_req();
        for (int k = 0; k < 3; k++) begin
            set_mc(2'b00, 1'b1, 32'h3000 + 32'(k));
            tick();
            n_checks++; if (bus.oSLB_done !== 1'b1 || bus.oSLB_nick !== 4'(7 + k))
                begin n_fail++; $display("FAIL pp_drain%0d got=%0b/%0h exp=1/%0h", k, bus.oSLB_done, bus.oSLB_nick, 7 + k); end
        end
        set_mc(2'b00, 1'b0, 32'h0); #1;
        n_checks++; if (bus.oMC_en !== 1'b0) begin n_fail++; $display("FAIL pp_empty got=%0b exp=0", bus.oMC_en); end
    endtask

    task automatic test_forward();
        logic [NICK_W-1:0] exp_nick[3];
        logic [DATA_W-1:0] exp_dt[3];
        int                n_exp;
        set_mc(2'b10, 1'b0, 32'h0);
        set_req(1'b1, 1'b1, 32'h200, 32'h12345678, 3'd4, 4'd1); tick();
        set_req(1'b1, 1'b0, 32'h200, 32'h0, 3'd1, 4'd5); tick();
        n_checks++; if (bus.oSLB_done !== 1'b0) begin n_fail++; $display("FAIL fwd_len_mismatch got=%0b exp=0", bus.oSLB_done); end
        set_req(1'b1, 1'b0, 32'h200, 32'h0, 3'd4, 4'd6); tick();
        idle_req(); #1;
`ifdef DCACHE_QUEUE_FWD_EN
        n_checks++; if (bus.oSLB_done !== 1'b1 || bus.oSLB_nick !== 4'd6 || bus.oSLB_dt !== 32'h12345678)
            begin n_fail++; $display("FAIL fwd_hit got=%0b/%0h/%0h exp=1/6/12345678", bus.oSLB_done, bus.oSLB_nick, bus.oSLB_dt); end
        exp_nick = '{4'd1, 4'd5, 4'd0}; exp_dt = '{32'h0, 32'hAAAA0001, 32'h0}; n_exp = 2;
`else
        n_checks++; if (bus.oSLB_done !== 1'b0) begin n_fail++; $display("FAIL nofwd_done got=%0b exp=0", bus.oSLB_done); end
        exp_nick = '{4'd1, 4'd5, 4'd6}; exp_dt = '{32'h0, 32'hAAAA0001, 32'hAAAA0002}; n_exp = 3;
`endif
        for (int k = 0; k < n_exp; k++) begin
            set_mc(2'b00, 1'b1, 32'hAAAA0000 + 32'(k));
            tick();
            n_checks++; if (bus.oSLB_done !== 1'b1 || bus.oSLB_nick !== exp_nick[k] || bus.oSLB_dt !== exp_dt[k])
                begin n_fail++; $display("FAIL fwd_drain%0d got=%0b/%0h/%0h exp=1/%0h/%0h", k, bus.oSLB_done, bus.oSLB_nick, bus.oSLB_dt, exp_nick[k], exp_dt[k]); end
        end
        set_mc(2'b00, 1'b0, 32'h0); #1;
        n_checks++; if (bus.oMC_en !== 1'b0) begin n_fail++; $display("FAIL fwd_empty got=%0b exp=0", bus.oMC_en); end
    endtask

    task automatic test_reset_mid();
        set_mc(2'b00, 1'b0, 32'h0);
        for (int i = 1; i <= 3; i++) begin
            set_req(1'b1, 1'b0, 32'h700 + 32'(4 * i), 32'h0, 3'd4, 4'(i)); tick();
        end
        idle_req(); rst = 1'b1; #1;
        n_checks++; if (bus.oMC_en !== 1'b0 || bus.oSLB_en !== 1'b0)
            begin n_fail++; $display("FAIL rst_high got=%0b/%0b exp=0/0", bus.oMC_en, bus.oSLB_en); end
        tick(); rst = 1'b0; #1;
        n_checks++; if (bus.oMC_en !== 1'b0 || bus.oSLB_done !== 1'b0 || bus.oSLB_en !== 1'b1)
            begin n_fail++; $display("FAIL rst_mid got=%0b/%0b/%0b exp=0/0/1", bus.oMC_en, bus.oSLB_done, bus.oSLB_en); end
        set_mc(2'b00, 1'b1, 32'hBAD); tick(); set_mc(2'b00, 1'b0, 32'h0); #1;
        n_checks++; if (bus.oSLB_done !== 1'b0 || bus.oMC_en !== 1'b0)
            begin n_fail++; $display("FAIL late_done got=%0b/%0b exp=0/0", bus.oSLB_done, bus.oMC_en); end
    endtask

    task automatic test_rdy_freeze();
        set_mc(2'b00, 1'b0, 32'h0);
        for (int i = 1; i <= 3; i++) begin
            set_req(1'b1, 1'b0, 32'h300 + 32'(4 * i), 32'h0, 3'd4, 4'(i)); tick();
        end
        idle_req(); set_mc(2'b00, 1'b1, 32'h11); tick();
        rdy = 1'b0; set_req(1'b1, 1'b0, 32'h3F0, 32'h0, 3'd4, 4'd9);
        for (int k = 0; k < 3; k++) begin
            set_mc(2'b00, 1'b1, 32'hEE00 + 32'(k)); #1;
            n_checks++; if (bus.oMC_en !== 1'b0 || bus.oSLB_en !== 1'b0)
                begin n_fail++; $display("FAIL freeze_en%0d got=%0b/%0b exp=0/0", k, bus.oMC_en, bus.oSLB_en); end
            tick();
            n_checks++; if (bus.oSLB_done !== 1'b1 || bus.oSLB_nick !== 4'd1 || bus.oSLB_dt !== 32'h11)
                begin n_fail++; $display("FAIL freeze_hold%0d got=%0b/%0h/%0h exp=1/1/11", k, bus.oSLB_done, bus.oSLB_nick, bus.oSLB_dt); end
        end
        rdy = 1'b1; idle_req();
        for (int k = 0; k < 2; k++) begin
            set_mc(2'b00, 1'b1, 32'h22 + 32'(17 * k)); tick();
            n_checks++; if (bus.oSLB_done !== 1'b1 || bus.oSLB_nick !== 4'(2 + k) || bus.oSLB_dt !== 32'h22 + 32'(17 * k))
                begin n_fail++; $display("FAIL resume%0d got=%0b/%0h/%0h exp=1/%0h/%0h", k, bus.oSLB_done, bus.oSLB_nick, bus.oSLB_dt, 2 + k, 32'h22 + 17 * k); end
        end
        set_mc(2'b00, 1'b0, 32'h0); tick();
        n_checks++; if (bus.oSLB_done !== 1'b0 || bus.oMC_en !== 1'b0)
            begin n_fail++; $display("FAIL resume_end got=%0b/%0b exp=0/0", bus.oSLB_done, bus.oMC_en); end
    endtask

    task automatic test_random();
        logic [LEN_W-1:0]  lens[3] = '{3'd1, 3'd2, 3'd4};
        logic              e_slb, e_mc, e_ls;
        logic [ADDR_W-1:0] e_pc;
        logic [DATA_W-1:0] e_dt;
        logic [LEN_W-1:0]  e_len;
        rst = 1'b1; tick(); rst = 1'b0;
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            rdy = ($urandom_range(0, 7) != 0);
            set_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'h100 + 32'(4 * $urandom_range(0, 2)),
                    $urandom, lens[$urandom_range(0, 2)], 4'($urandom_range(0, 15)));
            set_mc(2'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0), $urandom);
            #1;
            e_slb = rdy && !rst && (m_q.size() < DEPTH);
            e_mc  = rdy && !rst && (m_q.size() > 0) && !bus.iMC_wait[1];
            e_ls  = (m_q.size() > 0) ? m_q[0].ls  : 1'b0;
            e_pc  = (m_q.size() > 0) ? m_q[0].pc  : '0;
            e_dt  = (m_q.size() > 0) ? m_q[0].dt  : '0;
            e_len = (m_q.size() > 0) ? m_q[0].len : '0;
            n_checks++; if (bus.oSLB_en !== e_slb || bus.oMC_en !== e_mc)
                begin n_fail++; $display("FAIL rnd_en c=%0d got=%0b/%0b exp=%0b/%0b", c, bus.oSLB_en, bus.oMC_en, e_slb, e_mc); end
            n_checks++; if ({bus.oMC_ls, bus.oMC_pc, bus.oMC_dt, bus.oMC_len} !== {e_ls, e_pc, e_dt, e_len})
                begin n_fail++; $display("FAIL rnd_head c=%0d got=%0b/%0h/%0h/%0d exp=%0b/%0h/%0h/%0d", c, bus.oMC_ls, bus.oMC_pc, bus.oMC_dt, bus.oMC_len, e_ls, e_pc, e_dt, e_len); end
            tick();
            n_checks++; if (bus.oSLB_done !== m_done || (m_done && (bus.oSLB_nick !== m_nick || bus.oSLB_dt !== m_dt)))
                begin n_fail++; $display("FAIL rnd_done c=%0d got=%0b/%0h/%0h exp=%0b/%0h/%0h", c, bus.oSLB_done, bus.oSLB_nick, bus.oSLB_dt, m_done, m_nick, m_dt); end
        end
        rst = 1'b0; rdy = 1'b1; idle_req(); set_mc(2'b00, 1'b0, 32'h0);
    endtask

    initial begin
        idle_req();
        set_mc(2'b00, 1'b0, 32'h0);
        test_reset();
        test_single_load();
        test_fill_drain();
        test_full_push_pop();
        test_forward();
        test_reset_mid();
        test_rdy_freeze();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation time limit reached");
    end
endmodule
`default_nettype wire

// File: doc/dcache_queue.md
DCACHE_QUEUE -- requirements
Module: dcache_queue

Interface
REQ-001 SHALL have parameters (name, default, meaning): DEPTH, 4, request entries (power of 2, >=2); ADDR_W, 32, address width; DATA_W, 32, data width; LEN_W, 3, access length in bytes (1/2/4); NICK_W, 4, requester tag width.
REQ-002 SHALL have ports, one clock and one reset, reset synchronous and active-high:
 clk  in  1  clock
 rst  in  1  synchronous active-high reset
 rdy  in  1  global enable; low freezes all state
 iSLB_en  in  1  request valid
 iSLB_ls  in  1  0=load, 1=store
 iSLB_pc  in  ADDR_W  byte address
 iSLB_dt  in  DATA_W  store data
 iSLB_len  in  LEN_W  bytes
 iSLB_nick  in  NICK_W  tag
 oSLB_en  out  1  ready, can accept request
 oSLB_done  out  1  completion pulse
 oSLB_dt  out  DATA_W  load data (0 for stores)
 oSLB_nick  out  NICK_W  tag of completed request
 iMC_wait  in  2  bit1 high = memctrl busy for data port
 iMC_done  in  1  head access complete
 iMC_dt  in  DATA_W  load data from memctrl
 oMC_en  out  1  request to memctrl
 oMC_ls, oMC_pc, oMC_dt, oMC_len  out  1/ADDR_W/DATA_W/LEN_W  head entry fields

Function
REQ-003 SHALL hold a circular FIFO of DEPTH entries {ls, pc, dt, len, nick}, with head/tail pointers of log2(DEPTH) bits wrapping modulo DEPTH and a count of log2(DEPTH)+1 bits.
REQ-004 SHALL drive oSLB_en = rdy & ~rst & (count != DEPTH), combinationally.
REQ-005 SHALL push at the tail on a clk edge when iSLB_en & oSLB_en; iSLB_en while oSLB_en is low SHALL be ignored.
REQ-006 SHALL drive oMC_en = rdy & ~rst & (count != 0) & ~iMC_wait[1], combinationally; oMC_* fields SHALL equal the head entry whenever count != 0, otherwise 0.
REQ-007 SHALL issue strictly in order; only the head is ever presented; the head SHALL remain unchanged until iMC_done.
REQ-008 On a clk edge with rdy & iMC_done & count != 0: pop the head; next cycle oSLB_done=1 for exactly one cycle, oSLB_nick=head nick, oSLB_dt=iMC_dt for loads, 0 for stores (latency iMC_done -> oSLB_done: 1 cycle).
REQ-009 iMC_done with count == 0 SHALL be ignored.
REQ-010 Simultaneous push and pop SHALL leave count unchanged and both SHALL take effect; push when full is impossible (no pass-through).
REQ-011 oSLB_done SHALL be 0 in every cycle not following a completion.
REQ-012 With rdy low: no push, no pop, pointers/count/entries hold, oSLB_done holds its value, oMC_en=0.

Reset
REQ-013 On rst at a clk edge: head=tail=count=0, oSLB_done=0, oSLB_dt=0, oSLB_nick=0; entry contents need not be cleared.
REQ-014 While rst is high, oSLB_en=0 and oMC_en=0; rst mid-transaction SHALL discard all entries, including a head presented to memctrl.

Configuration
REQ-015 Macro DCACHE_QUEUE_FWD_EN SHALL compile in store-to-load forwarding; when undefined, all loads are enqueued per REQ-005.
REQ-016 With DCACHE_QUEUE_FWD_EN: an accepted load whose pc and len both equal those of a queued store (youngest match, head included) and with iMC_done=0 that cycle SHALL NOT be enqueued; next cycle oSLB_done=1, oSLB_nick=load nick, oSLB_dt=store dt masked to len low bytes, zero-extended.
REQ-017 With DCACHE_QUEUE_FWD_EN and iMC_done=1 in the same cycle, a matching load SHALL be enqueued normally (memctrl completion has priority, no forwarding).

Verification
REQ-018 Reset then push load {pc=0x100,len=4,nick=3}, iMC_wait=0 -> oMC_en=1 with pc=0x100 next cycle; iMC_done with iMC_dt=0xDEADBEEF -> oSLB_done=1, nick=3, dt=0xDEADBEEF one cycle later; count back to 0.
REQ-019 Push DEPTH=4 requests with iMC_wait[1]=1 -> oSLB_en=0 after the 4th, oMC_en=0; release wait -> entries complete in push order, nicks 0,1,2,3.
REQ-020 Full queue; iMC_done and iSLB_en in same cycle -> pop only, count=3, oSLB_en=1 next cycle; 6 push/pop cycles -> pointers wrap, order preserved.
REQ-021 Store {pc=0x200,len=4,dt=0x12345678} queued, then load {pc=0x200,len=1,nick=5} -> with DCACHE_QUEUE_FWD_EN: len mismatch, load enqueued; load {pc=0x200,len=4,nick=6} -> oSLB_done next cycle, dt=0x12345678, count unchanged; without macro: load enqueued, completes after store.
REQ-022 Assert rst while head presented and 2 entries queued -> next cycle count=0, oMC_en=0, oSLB_done=0; a late iMC_done is ignored.
REQ-023 Drop rdy for 3 cycles mid-stream with iMC_done pulses -> no state change, oMC_en=0; resume -> identical sequence to the uninterrupted run.
